// File: rtl/x_delay_line_pkg.sv
// Shared types and width helpers for the delay-line TDC measurement path.
// Default cell count and sync depth are also used when instantiating the cell chain.
package x_delay_line_pkg;

  localparam int P_CELLS_DEF = 64;
  localparam int P_SYNC_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  function automatic int cw_f(input int cells);
    return $clog2(cells + 1);
  endfunction

  function automatic int dw_f(input int cells, input int avg_log2);
    return cw_f(cells) + avg_log2;
  endfunction

endpackage

// File: rtl/x_delay_line_meas_popcount.sv
// Combinational population count of a thermometer snapshot.
// Every set bit is counted, so bubbles in the code do not truncate the result.
module x_popcount
  import x_delay_line_pkg::*;
#(
  parameter int  p_cells = P_CELLS_DEF,
  localparam int CW      = cw_f(p_cells)
) (
  input  logic [p_cells-1:0] i_vec,
  output logic [CW-1:0]      o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < p_cells; i++) begin
      o_cnt = o_cnt + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/x_delay_line_meas.sv
// Delay-line TDC measurement controller: launches edges into the cell chain, popcounts
// each synchronised snapshot and returns the accumulated sum over 2^p_avg_log2 samples.
//
// state  | meaning
// IDLE   | waiting for i_start, last result held on o_data
// LAUNCH | o_launch high, snapshot captured after p_sync cycles
// DRAIN  | o_launch low for p_sync+p_settle cycles, chain must empty
// OUTPUT | o_valid high until accepted by i_ready
module x_delay_line_meas
  import x_delay_line_pkg::*;
#(
  parameter int  p_cells    = P_CELLS_DEF,
  parameter int  p_sync     = P_SYNC_DEF,
  parameter int  p_settle   = 2,
  parameter int  p_avg_log2 = 4,
  localparam int CW         = cw_f(p_cells),
  localparam int DW         = dw_f(p_cells, p_avg_log2)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_launch,
  input  logic [p_cells-1:0] i_q,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DW-1:0]      o_data,
  output logic               o_sat,
  output logic               o_dirty
);

  localparam int NSAMP  = 1 << p_avg_log2;
  localparam int NDRAIN = p_sync + p_settle;
  localparam int SW     = (p_avg_log2 > 0) ? p_avg_log2 : 1;
  localparam int CTW    = $clog2(NDRAIN + 1);

  state_e         state_q;
  logic [SW-1:0]  samp_q;
  logic [CTW-1:0] cyc_q;
  logic [DW-1:0]  acc_q;
  logic           launch_q;
  logic           valid_q;
  logic           busy_q;
  logic           sat_q;
  logic           dirty_q;
  logic [CW-1:0]  pop;

  x_popcount #(.p_cells(p_cells)) u_popcount (
    .i_vec (i_q),
    .o_cnt (pop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      cyc_q    <= '0;
      acc_q    <= '0;
      launch_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      dirty_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q  <= LAUNCH;
            launch_q <= 1'b1;
            busy_q   <= 1'b1;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            dirty_q  <= 1'b0;
            samp_q   <= '0;
            cyc_q    <= '0;
          end
        end
        LAUNCH: begin
          if (cyc_q == CTW'(p_sync - 1)) begin
            acc_q    <= acc_q + DW'(pop);
            if (&i_q) sat_q <= 1'b1;
            launch_q <= 1'b0;
            cyc_q    <= '0;
            state_q  <= DRAIN;
          end else begin
            cyc_q <= cyc_q + CTW'(1);
          end
        end
        DRAIN: begin
          if (cyc_q == CTW'(NDRAIN - 1)) begin
            // Residue at the end of the drain means the chain did not empty in time.
            if (|i_q) dirty_q <= 1'b1;
            cyc_q <= '0;
            if (samp_q != SW'(NSAMP - 1)) begin
              samp_q   <= samp_q + SW'(1);
              launch_q <= 1'b1;
              state_q  <= LAUNCH;
            end else begin
              valid_q <= 1'b1;
              state_q <= OUTPUT;
            end
          end else begin
            cyc_q <= cyc_q + CTW'(1);
          end
        end
        OUTPUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          launch_q <= 1'b0;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_launch = launch_q;
  assign o_valid  = valid_q;
  assign o_data   = acc_q;
  assign o_sat    = sat_q;
  assign o_dirty  = dirty_q;

endmodule

// File: tb/tb_x_delay_line_meas.sv
// Bench for x_delay_line_meas: a delay-line model feeds per-sample snapshots and the
// expected sum, saturation and dirty flags are computed from the sample table.
module tb_x_delay_line_meas;

  localparam int P_CELLS    = 64;
  localparam int P_SYNC     = 4;
  localparam int P_SETTLE   = 2;
  localparam int P_AVG_LOG2 = 4;
  localparam int NSAMP      = 1 << P_AVG_LOG2;
  localparam int DW         = $clog2(P_CELLS + 1) + P_AVG_LOG2;
  localparam int PERIOD     = 2 * P_SYNC + P_SETTLE;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               ready = 1'b0;
  logic [P_CELLS-1:0] q;
  logic               busy, launch, valid, sat, dirty;
  logic [DW-1:0]      data;

  int n_checks = 0;
  int n_errors = 0;

  logic [P_CELLS-1:0] pat [NSAMP];
  int                 dirty_s  = -1;
  int                 base     = 0;
  int                 rise_cnt = 0;
  int                 idx_m;
  logic               ln_q = 1'b0;
  logic [P_SYNC-2:0]  sr = '0;

  x_delay_line_meas #(
    .p_cells(P_CELLS), .p_sync(P_SYNC), .p_settle(P_SETTLE), .p_avg_log2(P_AVG_LOG2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_launch(launch),
    .i_q(q), .o_valid(valid), .i_ready(ready), .o_data(data), .o_sat(sat), .o_dirty(dirty)
  );

  always #5 clk = ~clk;

  // Delay-line model: the snapshot appears a few cycles after launch and empties after it falls.
  always @(posedge clk) begin
    sr   <= {sr[P_SYNC-3:0], launch};
    ln_q <= launch;
    if (launch && !ln_q) rise_cnt <= rise_cnt + 1;
  end

  always_comb begin
    idx_m = rise_cnt - base - 1;
    q     = '0;
    if (idx_m >= 0 && idx_m < NSAMP) begin
      if (sr[P_SYNC-2]) q = pat[idx_m];
      else if (idx_m == dirty_s) q[0] = 1'b1;
    end
  end

  function automatic logic [P_CELLS-1:0] rand_pat();
    logic [P_CELLS-1:0] p;
    int len;
    len = $urandom_range(0, P_CELLS);
    p = '1;
    if (len < P_CELLS) p = (64'd1 << len) - 64'd1;
    if (len > 2 && $urandom_range(0, 1) == 1) p[$urandom_range(0, len - 2)] = 1'b0;
    return p;
  endfunction

  task automatic fill_const(input logic [P_CELLS-1:0] v);
    for (int s = 0; s < NSAMP; s++) pat[s] = v;
  endtask

  task automatic run_meas(input string name, input int hold, input bit poke);
    int n, exp_sum;
    bit exp_sat, exp_dirty;
    exp_sum = 0;
    exp_sat = 1'b0;
    for (int s = 0; s < NSAMP; s++) begin
      exp_sum += $countones(pat[s]);
      if (&pat[s]) exp_sat = 1'b1;
    end
    exp_dirty = (dirty_s >= 0 && dirty_s < NSAMP);
    @(negedge clk);
    base  = rise_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || launch !== 1'b1) begin
      n_errors++;
      $display("FAIL %s start: busy=%b launch=%b, required 1 1", name, busy, launch);
    end
    n = 0;
    while (valid !== 1'b1 && n < PERIOD * NSAMP + 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== PERIOD * NSAMP) begin
      n_errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, n, PERIOD * NSAMP);
    end
    n_checks++;
    if (data !== DW'(exp_sum) || sat !== exp_sat || dirty !== exp_dirty) begin
      n_errors++;
      $display("FAIL %s result: data=%0d sat=%b dirty=%b, required %0d %b %b",
               name, data, sat, dirty, exp_sum, exp_sat, exp_dirty);
    end
    for (int h = 0; h < hold; h++) begin
      start = poke && (h % 7 == 3);
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b1 || data !== DW'(exp_sum) || sat !== exp_sat || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL %s hold %0d: valid=%b data=%0d sat=%b busy=%b, required 1 %0d %b 1",
                 name, h, valid, data, sat, busy, exp_sum, exp_sat);
      end
    end
    ready = 1'b1;
    start = poke;
    @(negedge clk);
    ready = 1'b0;
    start = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || data !== DW'(exp_sum)) begin
      n_errors++;
      $display("FAIL %s accept: valid=%b busy=%b data=%0d, required 0 0 %0d",
               name, valid, busy, data, exp_sum);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || launch !== 1'b0) begin
      n_errors++;
      $display("FAIL %s idle after accept: busy=%b launch=%b, required 0 0", name, busy, launch);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || launch !== 1'b0 || valid !== 1'b0 || data !== '0 ||
        sat !== 1'b0 || dirty !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: busy=%b launch=%b valid=%b data=%0d sat=%b dirty=%b, required all 0",
               busy, launch, valid, data, sat, dirty);
    end
  endtask

  task automatic test_thermo();
    fill_const(64'h0000_0000_000F_FFFF);
    run_meas("thermo", 0, 1'b0);
  endtask

  task automatic test_bubble();
    fill_const(64'h0000_0000_000F_F7FF);
    run_meas("bubble", 0, 1'b0);
  endtask

  task automatic test_saturation();
    fill_const('1);
    run_meas("saturation", 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NSAMP; s++) pat[s] = rand_pat();
      if (r == 2) pat[$urandom_range(0, NSAMP - 1)] = '1;
      run_meas("random", 0, 1'b0);
    end
  endtask

  task automatic test_back_pressure();
    for (int s = 0; s < NSAMP; s++) pat[s] = rand_pat();
    pat[5] = '1;
    run_meas("backpressure", 30, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n;
    for (int s = 0; s < NSAMP; s++) pat[s] = rand_pat();
    @(negedge clk);
    base  = rise_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(idx_m == 7 && launch === 1'b1) && n < PERIOD * NSAMP) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (idx_m != 7) begin
      n_errors++;
      $display("FAIL reset_mid reach: sample=%0d, required 7", idx_m);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (launch !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || data !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: launch=%b busy=%b valid=%b data=%0d, required 0 0 0 0",
               launch, busy, valid, data);
    end
    repeat (6) @(negedge clk);
    fill_const(64'h0000_0000_0000_03FF);
    run_meas("after_reset", 0, 1'b0);
  endtask

  task automatic test_dirty();
    for (int s = 0; s < NSAMP; s++) pat[s] = rand_pat();
    dirty_s = 3;
    run_meas("dirty", 0, 1'b0);
    dirty_s = -1;
  endtask

  initial begin
    fill_const('0);
    test_reset();
    test_thermo();
    test_bubble();
    test_saturation();
    test_random();
    test_back_pressure();
    test_reset_mid();
    test_dirty();
    test_thermo();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
